// File: rtl/el_pkg.sv
// Shared types for the multi-rail bridge: FSM state encodings and digit
// code classes, plus a helper that classifies a digit by its rail count.
package el_pkg;

    typedef enum logic {
        RX_DATA = 1'b0,
        RX_NULL = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ACK  = 2'd1,
        TX_REL  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        CODE_NULL    = 2'd0,
        CODE_VALID   = 2'd1,
        CODE_ILLEGAL = 2'd2
    } code_e;

    function automatic code_e classify_digit(input int ones);
        if (ones == 0) begin
            return CODE_NULL;
        end else if (ones == 1) begin
            return CODE_VALID;
        end else begin
            return CODE_ILLEGAL;
        end
    endfunction

endpackage

// File: rtl/el_fifo.sv
// Circular word buffer between the receive and transmit sides; head word is
// presented combinationally, occupancy is a registered count.
module el_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [LW-1:0]    level_q;
    logic             doPush;
    logic             doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdata  = mem_q[rdPtr_q];
    assign level  = level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/el_sync_bridge.sv
// Bridges a four-phase multi-rail link into a clocked domain and back out,
// buffering complete words and flagging illegal codes.
module el_sync_bridge
    import el_pkg::*;
#(
    parameter int LINK_WIDTH  = 2,
    parameter int RAIL_NUM    = 2,
    parameter int PIPE_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [LINK_WIDTH*RAIL_NUM-1:0]      in,
    output logic                                ack_o,
    output logic [LINK_WIDTH*RAIL_NUM-1:0]      out,
    input  logic                                ack_i,
    output logic                                err,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]     level
);

    localparam int W = LINK_WIDTH * RAIL_NUM;

    logic [W-1:0]             inSync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0]   ackSync_q;
    logic [W-1:0]             syncWord;
    logic                     ackSync;

    logic                     wordData;
    logic                     wordNull;
    logic                     wordIllegal;
    logic                     anyNull;
    logic                     anyIllegal;

    rx_state_e                rxState_q, rxState_d;
    tx_state_e                txState_q, txState_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [W-1:0]             out_q, out_d;

    logic                     fifoPush;
    logic                     fifoPop;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [W-1:0]             fifoHead;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                inSync_q[k] <= '0;
            end
            ackSync_q <= '0;
        end else begin
            inSync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                inSync_q[k] <= inSync_q[k-1];
            end
            ackSync_q <= {ackSync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign syncWord = inSync_q[SYNC_STAGES-1];
    assign ackSync  = ackSync_q[SYNC_STAGES-1];

    // An illegal digit only counts once every digit has left NULL, so a word
    // still mid-transition is never mistaken for corruption.
    always_comb begin
        wordData   = 1'b1;
        wordNull   = 1'b1;
        anyNull    = 1'b0;
        anyIllegal = 1'b0;
        for (int d = 0; d < LINK_WIDTH; d++) begin
            case (classify_digit($countones(syncWord[d*RAIL_NUM +: RAIL_NUM])))
                CODE_NULL: begin
                    wordData = 1'b0;
                    anyNull  = 1'b1;
                end
                CODE_VALID: begin
                    wordNull = 1'b0;
                end
                default: begin
                    wordData   = 1'b0;
                    wordNull   = 1'b0;
                    anyIllegal = 1'b1;
                end
            endcase
        end
        wordIllegal = anyIllegal && !anyNull;
    end

    always_comb begin
        rxState_d = rxState_q;
        ack_d     = ack_q;
        err_d     = err_q;
        fifoPush  = 1'b0;
        case (rxState_q)
            RX_DATA: begin
                ack_d = 1'b0;
                if (wordData && !fifoFull) begin
                    fifoPush  = 1'b1;
                    ack_d     = 1'b1;
                    rxState_d = RX_NULL;
                end else if (wordIllegal) begin
                    err_d     = 1'b1;
                    ack_d     = 1'b1;
                    rxState_d = RX_NULL;
                end
            end
            RX_NULL: begin
                ack_d = 1'b1;
                if (wordNull) begin
                    ack_d     = 1'b0;
                    rxState_d = RX_DATA;
                end
            end
            default: begin
                ack_d     = 1'b0;
                rxState_d = RX_DATA;
            end
        endcase
    end

    always_comb begin
        txState_d = txState_q;
        out_d     = out_q;
        fifoPop   = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                if (!fifoEmpty && !ackSync) begin
                    out_d     = fifoHead;
                    fifoPop   = 1'b1;
                    txState_d = TX_ACK;
                end
            end
            TX_ACK: begin
                if (ackSync) begin
                    out_d     = '0;
                    txState_d = TX_REL;
                end
            end
            TX_REL: begin
                if (!ackSync) begin
                    txState_d = TX_IDLE;
                end
            end
            default: begin
                out_d     = '0;
                txState_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxState_q <= RX_DATA;
            txState_q <= TX_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            rxState_q <= rxState_d;
            txState_q <= txState_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            out_q     <= out_d;
        end
    end

    el_fifo #(
        .WIDTH (W),
        .DEPTH (PIPE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (syncWord),
        .rdata (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (level)
    );

    assign ack_o = ack_q;
    assign out   = out_q;
    assign err   = err_q;

endmodule

// File: tb/tb_el_sync_bridge.sv
// Scenario-driven bench for el_sync_bridge: directed handshakes plus randomized
// streaming checked against an in-order word queue.
module tb_el_sync_bridge;

    localparam int LINK_WIDTH  = 2;
    localparam int RAIL_NUM    = 2;
    localparam int PIPE_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int W           = LINK_WIDTH * RAIL_NUM;
    localparam int LVLW        = $clog2(PIPE_DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    inWord = '0;
    logic            ackI = 1'b0;
    logic            ackO;
    logic [W-1:0]    outWord;
    logic            err;
    logic [LVLW-1:0] level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    el_sync_bridge #(
        .LINK_WIDTH  (LINK_WIDTH),
        .RAIL_NUM    (RAIL_NUM),
        .PIPE_DEPTH  (PIPE_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (inWord),
        .ack_o (ackO),
        .out   (outWord),
        .ack_i (ackI),
        .err   (err),
        .level (level)
    );

    // Random complete word: every digit carries exactly one active rail.
    function automatic logic [W-1:0] randWord();
        logic [W-1:0]        w;
        logic [RAIL_NUM-1:0] digit;
        w = '0;
        for (int d = 0; d < LINK_WIDTH; d++) begin
            digit = '0;
            digit[$urandom_range(RAIL_NUM - 1)] = 1'b1;
            w[d*RAIL_NUM +: RAIL_NUM] = digit;
        end
        return w;
    endfunction

    function automatic bit isDataWord(input logic [W-1:0] w);
        for (int d = 0; d < LINK_WIDTH; d++) begin
            if ($countones(w[d*RAIL_NUM +: RAIL_NUM]) != 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst    = 1'b1;
        inWord = '0;
        ackI   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Upstream four-phase sender: present word, wait ack, return to NULL, wait release.
    task automatic sendWord(input logic [W-1:0] w, input int bound, output bit accepted);
        inWord   = w;
        accepted = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (ackO === 1'b1) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            inWord = '0;
            for (int i = 0; i < bound; i++) begin
                tick();
                if (ackO === 1'b0) break;
            end
        end
    endtask

    // Downstream four-phase receiver: ack_i follows completion of out.
    task automatic recvWord(input int bound, input int delay, output logic [W-1:0] w, output bit got);
        got = 1'b0;
        w   = '0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (outWord !== '0) begin
                got = 1'b1;
                w   = outWord;
                break;
            end
        end
        if (!got) return;
        repeat (delay) tick();
        ackI = 1'b1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (outWord === '0) break;
        end
        ackI = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        inWord = 4'b1001;
        ackI   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({ackO, err, level, outWord} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_hold cycle %0d: ack_o=%b err=%b level=%0d out=%b, required all zero",
                         c, ackO, err, level, outWord);
            end
        end
        rst    = 1'b0;
        inWord = '0;
        tick();
        total++;
        if ({ackO, err, level, outWord} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_release: ack_o=%b err=%b level=%0d out=%b, required all zero",
                     ackO, err, level, outWord);
        end
    endtask

    task automatic test_single_word();
        applyReset();
        inWord = 4'b1001;
        for (int e = 1; e <= SYNC_STAGES + 1; e++) begin
            tick();
            total++;
            if (ackO !== (e == SYNC_STAGES + 1)) begin
                bad++;
                $display("[TB] FAIL ack_rise edge %0d: ack_o=%b required %b", e, ackO, (e == SYNC_STAGES + 1));
            end
        end
        total++;
        if ({level, outWord} !== {LVLW'(1), 4'b0000}) begin
            bad++;
            $display("[TB] FAIL push_edge: level=%0d out=%b required level=1 out=0000", level, outWord);
        end
        tick();
        total++;
        if ({level, outWord} !== {LVLW'(0), 4'b1001}) begin
            bad++;
            $display("[TB] FAIL out_after_push: level=%0d out=%b required level=0 out=1001", level, outWord);
        end
        inWord = '0;
        for (int e = 1; e <= SYNC_STAGES + 1; e++) begin
            tick();
            total++;
            if (ackO !== (e < SYNC_STAGES + 1)) begin
                bad++;
                $display("[TB] FAIL ack_fall edge %0d: ack_o=%b required %b", e, ackO, (e < SYNC_STAGES + 1));
            end
        end
        ackI = 1'b1;
        for (int e = 1; e <= SYNC_STAGES + 1; e++) begin
            tick();
            total++;
            if (outWord !== ((e < SYNC_STAGES + 1) ? 4'b1001 : 4'b0000)) begin
                bad++;
                $display("[TB] FAIL out_release edge %0d: out=%b required %b", e, outWord,
                         ((e < SYNC_STAGES + 1) ? 4'b1001 : 4'b0000));
            end
        end
        ackI = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_illegal();
        applyReset();
        inWord = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if ({ackO, err} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL illegal_with_null cycle %0d: ack_o=%b err=%b required 0 0", c, ackO, err);
            end
        end
        inWord = 4'b0111;
        for (int e = 1; e <= SYNC_STAGES + 1; e++) begin
            tick();
            total++;
            if ({ackO, err} !== ((e == SYNC_STAGES + 1) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("[TB] FAIL illegal_ack edge %0d: ack_o=%b err=%b", e, ackO, err);
            end
        end
        total++;
        if ({level, outWord} !== '0) begin
            bad++;
            $display("[TB] FAIL illegal_no_push: level=%0d out=%b required 0 0000", level, outWord);
        end
        inWord = '0;
        repeat (SYNC_STAGES + 5) tick();
        total++;
        if ({ackO, err, level, outWord} !== {1'b0, 1'b1, LVLW'(0), 4'b0000}) begin
            bad++;
            $display("[TB] FAIL err_sticky: ack_o=%b err=%b level=%0d out=%b required 0 1 0 0000",
                     ackO, err, level, outWord);
        end
    endtask

    task automatic test_partial();
        applyReset();
        inWord = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({ackO, level} !== '0) begin
                bad++;
                $display("[TB] FAIL partial_hold cycle %0d: ack_o=%b level=%0d required 0 0", c, ackO, level);
            end
        end
        inWord = 4'b1001;
        for (int e = 1; e <= SYNC_STAGES + 1; e++) begin
            tick();
            total++;
            if (ackO !== (e == SYNC_STAGES + 1)) begin
                bad++;
                $display("[TB] FAIL partial_then_data edge %0d: ack_o=%b required %b", e, ackO, (e == SYNC_STAGES + 1));
            end
        end
        inWord = '0;
        repeat (6) tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words [PIPE_DEPTH + 2];
        logic [W-1:0] got;
        bit           acc;
        bit           ok;
        applyReset();
        for (int i = 0; i < PIPE_DEPTH + 2; i++) words[i] = randWord();
        // With downstream stalled, one word parks on out and PIPE_DEPTH fill the buffer.
        for (int i = 0; i < PIPE_DEPTH + 2; i++) begin
            sendWord(words[i], 20, acc);
            total++;
            if (acc !== (i < PIPE_DEPTH + 1)) begin
                bad++;
                $display("[TB] FAIL stall_accept word %0d: accepted=%b required %b", i, acc, (i < PIPE_DEPTH + 1));
            end
        end
        total++;
        if ({level, outWord} !== {LVLW'(PIPE_DEPTH), words[0]}) begin
            bad++;
            $display("[TB] FAIL stall_state: level=%0d out=%b required level=%0d out=%b",
                     level, outWord, PIPE_DEPTH, words[0]);
        end
        fork
            begin
                bit lateAcc;
                sendWord(words[PIPE_DEPTH + 1], 400, lateAcc);
                total++;
                if (lateAcc !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL stall_release: held word accepted=%b required 1", lateAcc);
                end
            end
            begin
                for (int i = 0; i < PIPE_DEPTH + 2; i++) begin
                    recvWord(200, 0, got, ok);
                    total++;
                    if (!ok || got !== words[i]) begin
                        bad++;
                        $display("[TB] FAIL stall_drain word %0d: got=%b present=%b required %b", i, got, ok, words[i]);
                    end
                end
            end
        join
        repeat (8) tick();
        total++;
        if (level !== '0) begin
            bad++;
            $display("[TB] FAIL stall_empty: level=%0d required 0", level);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] expQ [$];
        logic [W-1:0] sent [16];
        bit           done;
        applyReset();
        for (int i = 0; i < 16; i++) begin
            sent[i] = randWord();
            expQ.push_back(sent[i]);
        end
        done = 1'b0;
        fork
            begin
                fork
                    begin
                        bit acc;
                        for (int i = 0; i < 16; i++) begin
                            sendWord(sent[i], 300, acc);
                            total++;
                            if (acc !== 1'b1) begin
                                bad++;
                                $display("[TB] FAIL stream_accept word %0d: accepted=%b required 1", i, acc);
                            end
                        end
                    end
                    begin
                        logic [W-1:0] got;
                        logic [W-1:0] exp;
                        bit           ok;
                        for (int i = 0; i < 16; i++) begin
                            recvWord(300, $urandom_range(5), got, ok);
                            exp = expQ.pop_front();
                            total++;
                            if (!ok || got !== exp) begin
                                bad++;
                                $display("[TB] FAIL stream_order word %0d: got=%b present=%b required %b", i, got, ok, exp);
                            end
                        end
                    end
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    total++;
                    if (outWord !== '0 && !isDataWord(outWord)) begin
                        bad++;
                        $display("[TB] FAIL out_partial: out=%b is neither all-NULL nor complete", outWord);
                    end
                    total++;
                    if (level > LVLW'(PIPE_DEPTH)) begin
                        bad++;
                        $display("[TB] FAIL level_bound: level=%0d limit %0d", level, PIPE_DEPTH);
                    end
                end
            end
        join
        repeat (8) tick();
        total++;
        if ({level, outWord} !== '0) begin
            bad++;
            $display("[TB] FAIL stream_empty: level=%0d out=%b required 0 0000", level, outWord);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w [3];
        bit           acc;
        applyReset();
        sendWord(4'b0111, 20, acc);
        total++;
        if ({acc, err, level} !== {1'b1, 1'b1, LVLW'(0)}) begin
            bad++;
            $display("[TB] FAIL pre_reset_err: accepted=%b err=%b level=%0d required 1 1 0", acc, err, level);
        end
        for (int i = 0; i < 3; i++) begin
            w[i] = randWord();
            sendWord(w[i], 20, acc);
        end
        total++;
        if ({level, outWord} !== {LVLW'(2), w[0]}) begin
            bad++;
            $display("[TB] FAIL pre_reset_state: level=%0d out=%b required level=2 out=%b", level, outWord, w[0]);
        end
        // Arrange a push to be due on the very edge reset is sampled.
        inWord = randWord();
        repeat (SYNC_STAGES) tick();
        rst = 1'b1;
        tick();
        total++;
        if ({ackO, err, level, outWord} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset: ack_o=%b err=%b level=%0d out=%b required all zero",
                     ackO, err, level, outWord);
        end
        rst    = 1'b0;
        inWord = '0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_illegal();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
